// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// the two-byte opcode marker and the bubble / reset-vector constants.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_VEC   = 2'd0,
        ST_FETCH = 2'd1,
        ST_IMM   = 2'd2
    } state_t;

    localparam logic [3:0] IMM_OPC        = 4'hC;
    localparam logic [7:0] NOP_BYTE       = 8'h00;
    localparam logic [7:0] RESET_VEC_ADDR = 8'h00;

    function automatic logic is_two_byte(input logic [7:0] op_byte);
        return (op_byte[7:4] == IMM_OPC);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Hazard-unit controls, instruction-memory port and IF/ID outputs of the fetch stage.
interface if_stage_if;
    import if_stage_pkg::*;

    logic       pc_en;
    logic       if_id_en;
    logic       flush;
    logic       bt;
    logic [7:0] bt_target;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic [7:0] if_id_instr;
    logic [7:0] if_id_imm;
    logic [7:0] if_id_pc1;
    logic       if_id_valid;

    modport slave (
        input  pc_en, if_id_en, flush, bt, bt_target, imem_data,
        output imem_addr, if_id_instr, if_id_imm, if_id_pc1, if_id_valid
    );

    modport master (
        output pc_en, if_id_en, flush, bt, bt_target, imem_data,
        input  imem_addr, if_id_instr, if_id_imm, if_id_pc1, if_id_valid
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush forces a bubble, otherwise loads when enabled.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_flush,
    input  logic [7:0] i_instr,
    input  logic [7:0] i_imm,
    input  logic [7:0] i_pc1,
    input  logic       i_valid,
    output logic [7:0] o_instr,
    output logic [7:0] o_imm,
    output logic [7:0] o_pc1,
    output logic       o_valid
);

    // Pipeline register with reset, flush-to-bubble and enable-to-load
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            o_instr <= NOP_BYTE;
            o_imm   <= NOP_BYTE;
            o_pc1   <= NOP_BYTE;
            o_valid <= 1'b0;
        end else if (i_en) begin
            o_instr <= i_instr;
            o_imm   <= i_imm;
            o_pc1   <= i_pc1;
            o_valid <= i_valid;
        end else begin
            o_instr <= o_instr;
            o_imm   <= o_imm;
            o_pc1   <= o_pc1;
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: reset-vector load, PC, and assembly of one- or two-byte
// instructions into the IF/ID register.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    if_stage_if.slave   bus
);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [7:0] r_pend_instr, w_pend_instr_nxt;
    logic [7:0] r_pend_imm, w_pend_imm_nxt;
    logic [7:0] r_pend_pc, w_pend_pc_nxt;
    logic       r_pend_full, w_pend_full_nxt;

    logic       w_id_en, w_id_flush, w_id_valid;
    logic [7:0] w_id_instr, w_id_imm, w_id_pc1;

    assign w_pc_inc      = r_pc + 8'd1;
    assign bus.imem_addr = r_pc;

    // State, PC and pending-instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_VEC;
            r_pc         <= RESET_VEC_ADDR;
            r_pend_instr <= NOP_BYTE;
            r_pend_imm   <= NOP_BYTE;
            r_pend_pc    <= NOP_BYTE;
            r_pend_full  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_instr <= w_pend_instr_nxt;
            r_pend_imm   <= w_pend_imm_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_full  <= w_pend_full_nxt;
        end
    end

    // Next-state, PC and IF/ID data selection
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_instr_nxt = r_pend_instr;
        w_pend_imm_nxt   = r_pend_imm;
        w_pend_pc_nxt    = r_pend_pc;
        w_pend_full_nxt  = r_pend_full;
        w_id_en          = 1'b0;
        w_id_flush       = 1'b0;
        w_id_instr       = NOP_BYTE;
        w_id_imm         = NOP_BYTE;
        w_id_pc1         = NOP_BYTE;
        w_id_valid       = 1'b0;

        case (r_state)
            ST_VEC: begin
                w_pc_nxt    = bus.imem_data;
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_IMM: begin
                w_id_en    = bus.if_id_en;
                w_id_flush = bus.flush;
                if (bus.bt) begin
                    w_pc_nxt         = bus.bt_target;
                    w_state_nxt      = ST_FETCH;
                    w_pend_instr_nxt = NOP_BYTE;
                    w_pend_imm_nxt   = NOP_BYTE;
                    w_pend_pc_nxt    = NOP_BYTE;
                    w_pend_full_nxt  = 1'b0;
                end else if (r_state == ST_IMM) begin
                    if (bus.pc_en) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_FETCH;
                        if (bus.if_id_en) begin
                            w_id_instr = r_pend_instr;
                            w_id_imm   = bus.imem_data;
                            w_id_pc1   = w_pc_inc;
                            w_id_valid = 1'b1;
                        end else begin
                            w_pend_imm_nxt  = bus.imem_data;
                            w_pend_full_nxt = 1'b1;
                        end
                    end else begin
                        w_pend_full_nxt = r_pend_full;
                    end
                end else if (r_pend_full) begin
                    // A completed two-byte instruction waits here; fetch pauses until it issues
                    if (bus.if_id_en) begin
                        w_id_instr      = r_pend_instr;
                        w_id_imm        = r_pend_imm;
                        w_id_pc1        = r_pend_pc + 8'd2;
                        w_id_valid      = 1'b1;
                        w_pend_full_nxt = 1'b0;
                    end else begin
                        w_pend_full_nxt = 1'b1;
                    end
                end else if (bus.pc_en) begin
                    w_pc_nxt = w_pc_inc;
                    if (is_two_byte(bus.imem_data)) begin
                        w_pend_instr_nxt = bus.imem_data;
                        w_pend_pc_nxt    = r_pc;
                        w_state_nxt      = ST_IMM;
                    end else begin
                        w_id_instr = bus.imem_data;
                        w_id_pc1   = w_pc_inc;
                        w_id_valid = 1'b1;
                    end
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            default: begin
                w_state_nxt = ST_VEC;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_id_en),
        .i_flush (w_id_flush),
        .i_instr (w_id_instr),
        .i_imm   (w_id_imm),
        .i_pc1   (w_id_pc1),
        .i_valid (w_id_valid),
        .o_instr (bus.if_id_instr),
        .o_imm   (bus.if_id_imm),
        .o_pc1   (bus.if_id_pc1),
        .o_valid (bus.if_id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for the fetch stage with a behavioural instruction memory.
module tb_if_stage;
    import if_stage_pkg::*;

    typedef struct {
        logic       rst;
        logic       pe;
        logic       ie;
        logic       fl;
        logic       bt;
        logic [7:0] tgt;
        logic [7:0] addr;
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] pc1;
        logic       valid;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] mem [256];
    int         n_tests;
    int         n_fail;
    vec_t       tbl_a[$];
    vec_t       tbl_b[$];

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic step(input logic r, input logic pe, input logic ie,
                        input logic fl, input logic b, input logic [7:0] tgt);
        rst           = r;
        bus.pc_en     = pe;
        bus.if_id_en  = ie;
        bus.flush     = fl;
        bus.bt        = b;
        bus.bt_target = tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input int idx, input logic [7:0] addr,
                         input logic [7:0] instr, input logic [7:0] imm,
                         input logic [7:0] pc1, input logic valid);
        n_tests++;
        if (bus.imem_addr !== addr || bus.if_id_instr !== instr || bus.if_id_imm !== imm ||
            bus.if_id_pc1 !== pc1 || bus.if_id_valid !== valid) begin
            n_fail++;
            $display("FAIL %s[%0d]: got addr=%h instr=%h imm=%h pc1=%h valid=%b, expected addr=%h instr=%h imm=%h pc1=%h valid=%b",
                     nm, idx, bus.imem_addr, bus.if_id_instr, bus.if_id_imm, bus.if_id_pc1,
                     bus.if_id_valid, addr, instr, imm, pc1, valid);
        end
    endtask

    task automatic run_table(input string nm, input vec_t t[$]);
        foreach (t[i]) begin
            step(t[i].rst, t[i].pe, t[i].ie, t[i].fl, t[i].bt, t[i].tgt);
            check(nm, i, t[i].addr, t[i].instr, t[i].imm, t[i].pc1, t[i].valid);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.pc_en = 1'b0; bus.if_id_en = 1'b0; bus.flush = 1'b0;
        bus.bt = 1'b0; bus.bt_target = 8'h00;

        //                rst   pe    ie    fl    bt    tgt    addr   instr  imm    pc1    valid
        tbl_a.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 8'h15, 8'h00, 8'h41, 1'b1});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 8'h26, 8'h00, 8'h42, 1'b1});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h43, 8'h37, 8'h00, 8'h43, 1'b1});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h45, 8'h59, 8'h00, 8'h45, 1'b1});
        tbl_a.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h45, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 8'h15, 8'h00, 8'h41, 1'b1});
        tbl_a.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h41, 8'h15, 8'h00, 8'h41, 1'b1});
        tbl_a.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h41, 8'h15, 8'h00, 8'h41, 1'b1});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 8'h26, 8'h00, 8'h42, 1'b1});
        tbl_a.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h43, 8'h37, 8'h00, 8'h43, 1'b1});

        tbl_b.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 8'hC4, 8'h9A, 8'h42, 1'b1});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h43, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h81, 8'h11, 8'h00, 8'h81, 1'b1});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h82, 8'h22, 8'h00, 8'h82, 1'b1});

        @(negedge clk);

        clear_mem();
        mem[8'h00] = 8'h40;
        mem[8'h40] = 8'h15; mem[8'h41] = 8'h26; mem[8'h42] = 8'h37;
        mem[8'h43] = 8'h48; mem[8'h44] = 8'h59;
        run_table("seq", tbl_a);

        clear_mem();
        mem[8'h00] = 8'h40;
        mem[8'h40] = 8'hC4; mem[8'h41] = 8'h9A; mem[8'h42] = 8'hC4; mem[8'h43] = 8'h77;
        mem[8'h80] = 8'h11; mem[8'h81] = 8'h22;
        run_table("imm", tbl_b);

        // Wrap-around: two-byte opcode at 0xFF, immediate at 0x00
        clear_mem();
        mem[8'h00] = 8'hFF;
        mem[8'hFF] = 8'hC1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap", 0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        mem[8'h00] = 8'h55;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap", 1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap", 2, 8'h01, 8'hC1, 8'h55, 8'h01, 1'b1);

        // Immediate fetched while IF/ID is frozen is held, then issued
        clear_mem();
        mem[8'h00] = 8'h40;
        mem[8'h40] = 8'hC4; mem[8'h41] = 8'h9A; mem[8'h42] = 8'h15;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("hold", 0, 8'h41, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("hold", 1, 8'h42, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("hold", 2, 8'h42, 8'hC4, 8'h9A, 8'h42, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("hold", 3, 8'h43, 8'h15, 8'h00, 8'h43, 1'b1);

        // Reset in the middle of a two-byte instruction
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rstimm", 0, 8'h41, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rstimm", 1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rstimm", 2, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("rstimm", 3, 8'h41, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port pc_en, input, 1 bit: from the hazard unit; 0 freezes the PC.
REQ-004 The block SHALL have port if_id_en, input, 1 bit: from the hazard unit; 0 freezes the IF/ID outputs.
REQ-005 The block SHALL have port flush, input, 1 bit: from the hazard unit; 1 bubbles the IF/ID outputs.
REQ-006 The block SHALL have port bt, input, 1 bit: branch taken; 1 redirects the PC.
REQ-007 The block SHALL have port bt_target, input, 8 bits: branch destination address.
REQ-008 The block SHALL have port imem_data, input, 8 bits: combinational instruction-memory read data for imem_addr.
REQ-009 The block SHALL have port imem_addr, output, 8 bits: equal to the PC register.
REQ-010 The block SHALL have port if_id_instr, output, 8 bits: latched opcode byte; [7:4] is the opcode, [3:2] is ra, [1:0] is rb.
REQ-011 The block SHALL have port if_id_imm, output, 8 bits: latched immediate byte, 0 for one-byte instructions.
REQ-012 The block SHALL have port if_id_pc1, output, 8 bits: address following the last byte of the latched instruction.
REQ-013 The block SHALL have port if_id_valid, output, 1 bit: 1 when the IF/ID contents are a real instruction, 0 for a bubble.

Function
REQ-014 The block SHALL implement a three-state FSM: VEC, FETCH and IMM.
REQ-015 In VEC, imem_addr SHALL be 0x00; on the next edge the PC SHALL load imem_data (the reset vector), the state SHALL become FETCH, and IF/ID SHALL stay a bubble; pc_en, if_id_en, flush and bt SHALL be ignored in VEC.
REQ-016 In FETCH with opcode imem_data[7:4] not equal to IMM_OPC (4'hC) and pc_en=1, on the next edge: PC<=PC+1; if if_id_en=1, then if_id_instr<=imem_data, if_id_imm<=0, if_id_pc1<=PC+1 and if_id_valid<=1.
REQ-017 In FETCH with opcode equal to IMM_OPC and pc_en=1, on the next edge: the opcode byte and PC SHALL be captured into internal pending registers, PC<=PC+1, and the state SHALL become IMM.
REQ-018 In FETCH with opcode equal to IMM_OPC and pc_en=1, if if_id_en=1 the IF/ID outputs SHALL become a bubble (if_id_valid=0, all other IF/ID outputs 0).
REQ-019 In IMM with pc_en=1, on the next edge: if_id_instr<=pending byte, if_id_imm<=imem_data, if_id_pc1<=PC+1, if_id_valid<=1, PC<=PC+1, and the state SHALL become FETCH.
REQ-020 In IMM with pc_en=1 and if_id_en=0, the PC and state SHALL advance while the immediate SHALL be held in the pending registers until if_id_en=1.
REQ-021 pc_en=0 SHALL hold the PC, the state and the pending registers.
REQ-022 if_id_en=0 SHALL hold all IF/ID outputs, unless flush=1.
REQ-023 flush=1 SHALL force the IF/ID outputs to a bubble on the next edge, regardless of if_id_en.
REQ-024 bt=1 SHALL set PC<=bt_target, discard any pending byte and set state<=FETCH on the next edge, regardless of pc_en.
REQ-025 Priority SHALL be: rst, then bt/flush, then stall, then normal operation; bt and flush asserted together SHALL both take effect.
REQ-026 PC arithmetic SHALL be modulo 256: PC=0xFF advances to 0x00, and an immediate fetched at 0x00 after an opcode at 0xFF is legal.

Reset
REQ-027 While rst=1 on an edge: state<=VEC, PC<=0x00, pending registers<=0, if_id_instr/imm/pc1<=0x00, if_id_valid<=0.
REQ-028 Reset mid-IMM SHALL discard the pending byte, and no partial instruction SHALL ever appear with if_id_valid=1.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, IMM_OPC=4'hC, the NOP/bubble value 8'h00 and the reset-vector address 8'h00.
REQ-030 The IF/ID register set (enable, flush, valid) SHALL be a sub-module named if_id_reg; the FSM and PC SHALL remain in if_stage.

Verification
REQ-031 The bench SHALL cover reset vector: mem[0]=0x40, release rst -> imem_addr=0x00 for 1 cycle, then 0x40; first valid IF/ID one cycle later.
REQ-032 The bench SHALL cover sequential one-byte instructions: mem[0x40..0x42]=0x15,0x26,0x37 -> if_id_instr 0x15,0x26,0x37 on consecutive cycles with pc1 0x41,0x42,0x43.
REQ-033 The bench SHALL cover a two-byte instruction: mem[0x40]=0xC4, mem[0x41]=0x9A -> one bubble, then instr=0xC4, imm=0x9A, pc1=0x42, valid=1.
REQ-034 The bench SHALL cover a load-use stall: pc_en=if_id_en=0 for 2 cycles at PC=0x41 -> PC and IF/ID held; resumes with no lost or duplicated instruction.
REQ-035 The bench SHALL cover branch during IMM: bt=1, flush=1, bt_target=0x80 while in IMM -> next cycle PC=0x80, valid=0, state FETCH, and the pending 0xC4 is never issued.
REQ-036 The bench SHALL cover wrap-around: opcode 0xC1 at 0xFF, imm 0x55 at 0x00 -> instr=0xC1, imm=0x55, pc1=0x01.
